serial_sub: RTL and testbench

- Multi-cycle, bit-serial WIDTH-bit subtractor for the RISC ALU; the inverse companion of the combinational 8-bit ADD unit.
- Computes D = A - B one bit per clock, LSB first, using a ripple borrow held in a flop.
- Reports borrow, zero and signed-overflow flags.
- Uses a start/busy/done handshake so the ALU control FSM can issue and collect subtract operations.

---
 rtl/serial_sub_pkg.sv | 21 ++
 rtl/serial_sub_fs.sv | 13 +
 rtl/serial_sub.sv | 137 +++++++++++++
 tb/tb_serial_sub.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding, default width
// and the counter-width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int SUB_WIDTH_DEF = 8;

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int n;
    n = 1;
    while ((1 << n) < value) n++;
    return n;
  endfunction

endpackage

// File: rtl/serial_sub_fs.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module sub_fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor D = A - B, LSB first, with start/busy/done handshake.
// Optional signed saturation of D on overflow when SERIAL_SUB_SAT_EN is defined.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             borrow,
  output logic             zero,
  output logic             ovf
);

  localparam int            CW   = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: start is accepted at a rising edge only in IDLE or DONE (busy=0);
  // done is high for exactly the one cycle after the final bit, when D/flags update.
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_acc;
  logic             r_br;
  logic             r_a_sgn;
  logic             r_b_sgn;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_d;
  logic             r_borrow;
  logic             r_zero;
  logic             r_ovf;

  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic [WIDTH-1:0] w_final;
  logic             w_accept;

  sub_fs u_fs (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bout)
  );

  // The new bit enters at the top; after the last bit the word is LSB-aligned.
  assign w_res    = {w_d, r_acc};
  assign w_ovf    = (r_a_sgn != r_b_sgn) && (w_res[WIDTH-1] != r_a_sgn);
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef SERIAL_SUB_SAT_EN
  assign w_final = !w_ovf  ? w_res :
                   r_a_sgn ? {1'b1, {(WIDTH-1){1'b0}}} :
                             {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign w_final = w_res;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_br     <= 1'b0;
      r_a_sgn  <= 1'b0;
      r_b_sgn  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_d      <= '0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_a     <= A;
            r_b     <= B;
            r_acc   <= '0;
            r_br    <= 1'b0;
            r_a_sgn <= A[WIDTH-1];
            r_b_sgn <= B[WIDTH-1];
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_bout;
          r_acc <= w_res[WIDTH-1:1];
          if (r_cnt == LAST) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_d      <= w_final;
            r_borrow <= w_bout;
            r_zero   <= (w_final == '0);
            r_ovf    <= w_ovf;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign D      = r_d;
  assign borrow = r_borrow;
  assign zero   = r_zero;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub (WIDTH=8): vector table plus hand-written
// sequences for start-while-busy, reset mid-run and back-to-back operation.
module tb_serial_sub;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] d_out;
  logic         borrow;
  logic         zero;
  logic         ovf;

  int n_checks = 0;
  int n_pass   = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A      (a_in),
    .B      (b_in),
    .busy   (busy),
    .done   (done),
    .D      (d_out),
    .borrow (borrow),
    .zero   (zero),
    .ovf    (ovf)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         br;
    logic         z;
    logic         v;
  } vec_t;

  vec_t vecs[9];

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Called right after the accepting edge; returns ticks until done and busy cycles seen.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < 30) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input vec_t v);
    check({tag, "_D"},      {24'd0, d_out},  {24'd0, v.d});
    check({tag, "_borrow"}, {31'd0, borrow}, {31'd0, v.br});
    check({tag, "_zero"},   {31'd0, zero},   {31'd0, v.z});
    check({tag, "_ovf"},    {31'd0, ovf},    {31'd0, v.v});
  endtask

  // Scoreboard of expected D values for the back-to-back sequence
  logic [W-1:0] exp_q[$];

  initial begin
    int lat;
    int bcnt;
    int done_seen;
    logic [W-1:0] prev_d;

`ifdef SERIAL_SUB_SAT_EN
    vecs[0] = '{8'h0A, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h05, 8'h0A, 8'hFB, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h3C, 8'h3C, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'hFF, 8'h7F, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{8'h00, 8'h80, 8'h7F, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{8'hC8, 8'h32, 8'h96, 1'b0, 1'b0, 1'b0};
`else
    vecs[0] = '{8'h0A, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h05, 8'h0A, 8'hFB, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h3C, 8'h3C, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{8'h00, 8'h80, 8'h80, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{8'hC8, 8'h32, 8'h96, 1'b0, 1'b0, 1'b0};
`endif

    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    tick();
    tick();
    check("rst_busy",   {31'd0, busy},   32'd0);
    check("rst_done",   {31'd0, done},   32'd0);
    check("rst_D",      {24'd0, d_out},  32'd0);
    check("rst_borrow", {31'd0, borrow}, 32'd0);
    check("rst_zero",   {31'd0, zero},   32'd0);
    check("rst_ovf",    {31'd0, ovf},    32'd0);
    rst_n = 1'b1;
    tick();

    // Vector table: latency, busy window, result, single-cycle done
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].a, vecs[i].b);
      wait_done(lat, bcnt);
      check($sformatf("v%0d_latency", i), lat, 32'd8);
      check($sformatf("v%0d_busy_cycles", i), bcnt, 32'd8);
      check($sformatf("v%0d_busy_at_done", i), {31'd0, busy}, 32'd0);
      check_result($sformatf("v%0d", i), vecs[i]);
      tick();
      check($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
      check($sformatf("v%0d_D_hold", i), {24'd0, d_out}, {24'd0, vecs[i].d});
      tick();
    end

    // start and operand changes during RUN are ignored; D holds the old result
    prev_d = vecs[8].d;
    issue(8'h07, 8'h03);
    tick();
    tick();
    check("ign_D_hold_run", {24'd0, d_out}, {24'd0, prev_d});
    a_in  = 8'h01;
    b_in  = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    a_in  = 8'hAA;
    b_in  = 8'h55;
    wait_done(lat, bcnt);
    check("ign_latency", lat + 3, 32'd8);
    check_result("ign", '{8'h07, 8'h03, 8'h04, 1'b0, 1'b0, 1'b0});
    tick();
    tick();
    check("ign_no_second_op", {31'd0, busy}, 32'd0);

    // Reset mid-run abandons the operation and clears the outputs
    issue(8'h10, 8'h01);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("rstrun_busy", {31'd0, busy},   32'd0);
    check("rstrun_done", {31'd0, done},   32'd0);
    check("rstrun_D",    {24'd0, d_out},  32'd0);
    check("rstrun_flags", {29'd0, borrow, zero, ovf}, 32'd0);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) done_seen++;
    end
    check("rstrun_no_done", done_seen, 32'd0);
    check("rstrun_D_after", {24'd0, d_out}, 32'd0);

    // Back-to-back: start held through DONE, second op accepted on the DONE edge
    exp_q.push_back(8'h05);
    exp_q.push_back(8'h1F);
    a_in  = 8'h0A;
    b_in  = 8'h05;
    start = 1'b1;
    tick();
    wait_done(lat, bcnt);
    check("b2b_first_latency", lat, 32'd8);
    check("b2b_first_D", {24'd0, d_out}, {24'd0, exp_q.pop_front()});
    a_in = 8'h20;
    b_in = 8'h01;
    tick();
    start = 1'b0;
    check("b2b_busy_again", {31'd0, busy}, 32'd1);
    wait_done(lat, bcnt);
    check("b2b_done_spacing", lat + 1, 32'd9);
    check("b2b_second_D", {24'd0, d_out}, {24'd0, exp_q.pop_front()});
    check("b2b_second_borrow", {31'd0, borrow}, 32'd0);
    tick();
    check("b2b_idle", {30'd0, busy, done}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
